// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit.
// Holds the op code width and the op code encodings used by the core and the bench.
package logic_unit_pkg;

  localparam int unsigned LU_OP_W = 3;

  localparam logic [LU_OP_W-1:0] LU_OR    = 3'b000;
  localparam logic [LU_OP_W-1:0] LU_XOR   = 3'b001;
  localparam logic [LU_OP_W-1:0] LU_AND   = 3'b010;
  localparam logic [LU_OP_W-1:0] LU_NOTA  = 3'b011;
  localparam logic [LU_OP_W-1:0] LU_NOR   = 3'b100;
  localparam logic [LU_OP_W-1:0] LU_XNOR  = 3'b101;
  localparam logic [LU_OP_W-1:0] LU_NAND  = 3'b110;
  localparam logic [LU_OP_W-1:0] LU_PASSA = 3'b111;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise logic unit: maps (a, b, op) to a result plus zero and parity flags.
// Ports:
//   a, b    operands (data_size bits)
//   op      operation select (LU_OP_W bits)
//   result  bitwise result (data_size bits)
//   zero    result == 0
//   parity  XOR-reduce of result
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned data_size = 8
) (
  input  logic [data_size-1:0] a,
  input  logic [data_size-1:0] b,
  input  logic [LU_OP_W-1:0]   op,
  output logic [data_size-1:0] result,
  output logic                 zero,
  output logic                 parity
);

  always_comb begin
    result = '0;
    case (op)
      LU_OR:    result = a | b;
      LU_XOR:   result = a ^ b;
      LU_AND:   result = a & b;
      LU_NOTA:  result = ~a;
      LU_NOR:   result = ~(a | b);
      LU_XNOR:  result = ~(a ^ b);
      LU_NAND:  result = ~(a & b);
      LU_PASSA: result = a;
      default:  result = '0;
    endcase
    zero   = ~|result;
    parity = ^result;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with valid/ready handshakes on both sides.
// S1 captures the operands and op code; S2 registers the core's result and flags.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   a_in, b_in      operands
//   op_code         operation select
//   in_valid        input handshake valid
//   in_ready        input handshake ready (combinational from out_ready, low in reset)
//   result_out      registered result
//   zero_out        result_out == 0
//   parity_out      XOR-reduce of result_out
//   out_valid       output handshake valid
//   out_ready       output handshake ready
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned data_size    = 8,
  parameter int unsigned op_code_size = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [data_size-1:0]    a_in,
  input  logic [data_size-1:0]    b_in,
  input  logic [op_code_size-1:0] op_code,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [data_size-1:0]    result_out,
  output logic                    zero_out,
  output logic                    parity_out,
  output logic                    out_valid,
  input  logic                    out_ready
);

  if (op_code_size != LU_OP_W) begin : g_op_w_check
    $error("logic_unit_pipe: op_code_size must be 3");
  end

  logic                    s1_v;
  logic [data_size-1:0]    s1_a;
  logic [data_size-1:0]    s1_b;
  logic [op_code_size-1:0] s1_op;

  logic                    s2_adv;
  logic                    s1_adv;

  logic [data_size-1:0]    core_result;
  logic                    core_zero;
  logic                    core_parity;

  // A stage may advance when it is empty or the stage after it is moving.
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_v || s2_adv;
    in_ready = s1_adv && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_op <= '0;
    end else if (s1_adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a  <= a_in;
        s1_b  <= b_in;
        s1_op <= op_code;
      end
    end
  end

  logic_unit_core #(
    .data_size (data_size)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .zero   (core_zero),
    .parity (core_parity)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result_out <= '0;
      zero_out   <= 1'b1;
      parity_out <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_v;
      if (s1_v) begin
        result_out <= core_result;
        zero_out   <= core_zero;
        parity_out <= core_parity;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboarded bench for logic_unit_pipe (data_size = 8).
// Accepted inputs push their hand-computed expected result; a monitor pops on each
// output transfer and also checks that outputs hold while stalled.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [2:0] op_code;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] result_out;
  logic       zero_out;
  logic       parity_out;
  logic       out_valid;
  logic       out_ready;

  logic_unit_pipe #(
    .data_size    (8),
    .op_code_size (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a_in       (a_in),
    .b_in       (b_in),
    .op_code    (op_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result_out (result_out),
    .zero_out   (zero_out),
    .parity_out (parity_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       p;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   errors = 0;
  int   checks = 0;
  int   popped = 0;
  int   cyc    = 0;
  logic rand_mode = 1'b0;

  vec_t stream_v[8];
  vec_t flag_v[8];

  function automatic vec_t mkv(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                               input logic [7:0] r, input logic z, input logic p);
    vec_t v;
    v.a   = a;
    v.b   = b;
    v.op  = op;
    v.e.r = r;
    v.e.z = z;
    v.e.p = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard push: an accepted input transfers at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) sb.push_back(cur_exp);
  end

  // Monitor: pop/compare on output transfers, check stability while stalled.
  logic hold_prev = 1'b0;
  exp_t prev;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_result", result_out, prev.r);
        chk("hold_flags", {zero_out, parity_out}, {prev.z, prev.p});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected no output at %0t", result_out, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          popped++;
          chk("result", result_out, e.r);
          chk("zero", zero_out, e.z);
          chk("parity", parity_out, e.p);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev      = '{r: result_out, z: zero_out, p: parity_out};
    end
  end

  // Random output back-pressure, only while rand_mode is set.
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Drive one op and wait (bounded) for its transfer. Entered and left at posedge+1.
  task automatic send(input vec_t v);
    int n;
    a_in     = v.a;
    b_in     = v.b;
    op_code  = v.op;
    cur_exp  = v.e;
    in_valid = 1'b1;
    n        = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;
    int pb;

    // a=F0, b=3C over all ops
    stream_v[0] = mkv(8'hF0, 8'h3C, 3'b000, 8'hFC, 1'b0, 1'b0);
    stream_v[1] = mkv(8'hF0, 8'h3C, 3'b001, 8'hCC, 1'b0, 1'b0);
    stream_v[2] = mkv(8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0, 1'b0);
    stream_v[3] = mkv(8'hF0, 8'h3C, 3'b011, 8'h0F, 1'b0, 1'b0);
    stream_v[4] = mkv(8'hF0, 8'h3C, 3'b100, 8'h03, 1'b0, 1'b0);
    stream_v[5] = mkv(8'hF0, 8'h3C, 3'b101, 8'h33, 1'b0, 1'b0);
    stream_v[6] = mkv(8'hF0, 8'h3C, 3'b110, 8'hCF, 1'b0, 1'b0);
    stream_v[7] = mkv(8'hF0, 8'h3C, 3'b111, 8'hF0, 1'b0, 1'b0);
    // flag-oriented vectors
    flag_v[0] = mkv(8'h55, 8'h55, 3'b001, 8'h00, 1'b1, 1'b0);
    flag_v[1] = mkv(8'h01, 8'hA7, 3'b111, 8'h01, 1'b0, 1'b1);
    flag_v[2] = mkv(8'h07, 8'h00, 3'b000, 8'h07, 1'b0, 1'b1);
    flag_v[3] = mkv(8'hFF, 8'hFF, 3'b110, 8'h00, 1'b1, 1'b0);
    flag_v[4] = mkv(8'h80, 8'h00, 3'b100, 8'h7F, 1'b0, 1'b1);
    flag_v[5] = mkv(8'hC3, 8'h81, 3'b101, 8'hBD, 1'b0, 1'b0);
    flag_v[6] = mkv(8'hFE, 8'h33, 3'b011, 8'h01, 1'b0, 1'b1);
    flag_v[7] = mkv(8'hA5, 8'h0F, 3'b010, 8'h05, 1'b0, 1'b0);

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    op_code   = '0;
    cur_exp   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", result_out, 8'h00);
    chk("reset_zero", zero_out, 1'b1);
    chk("reset_parity", parity_out, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Latency: visible on the second cycle after the transfer edge
    send(stream_v[0]);
    @(negedge clk);
    chk("latency_cycle1", out_valid, 1'b0);
    @(negedge clk);
    chk("latency_cycle2", out_valid, 1'b1);
    @(posedge clk);
    #1;
    drain("drain_latency");

    // Streaming at one op per cycle
    start = cyc;
    foreach (stream_v[i]) send(stream_v[i]);
    chk("throughput_cycles", cyc - start, 8);
    drain("drain_stream");

    // Flags
    foreach (flag_v[i]) send(flag_v[i]);
    drain("drain_flags");

    // Back-pressure: two accepted, third blocked, result holds first value
    pb = popped;
    out_ready = 1'b0;
    send(flag_v[2]);
    send(flag_v[3]);
    fork
      send(flag_v[4]);
      begin
        @(negedge clk);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_result", result_out, 8'h07);
        repeat (2) @(negedge clk);
        chk("bp_in_ready_late", in_ready, 1'b0);
        chk("bp_result_late", result_out, 8'h07);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    chk("bp_count", popped - pb, 3);

    // Simultaneous in/out transfer with both stages full
    out_ready = 1'b0;
    send(flag_v[5]);
    send(flag_v[6]);
    out_ready = 1'b1;
    a_in      = flag_v[7].a;
    b_in      = flag_v[7].b;
    op_code   = flag_v[7].op;
    cur_exp   = flag_v[7].e;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("simul_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("simul_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    drain("drain_simul");

    // Reset with two ops in flight; neither may emerge afterwards
    out_ready = 1'b0;
    send(mkv(8'hAA, 8'h00, 3'b111, 8'hAA, 1'b0, 1'b0));
    send(mkv(8'h3C, 8'hC3, 3'b000, 8'hFF, 1'b0, 1'b0));
    rst = 1'b1;
    sb.delete();
    a_in     = 8'h12;
    b_in     = 8'h34;
    op_code  = 3'b000;
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_result", result_out, 8'h00);
    chk("rst_mid_zero", zero_out, 1'b1);
    chk("rst_mid_parity", parity_out, 1'b0);
    @(posedge clk);
    #1;
    send(mkv(8'h0F, 8'hF0, 3'b001, 8'hFF, 1'b0, 1'b0));
    @(negedge clk);
    chk("post_rst_cycle1", out_valid, 1'b0);
    @(negedge clk);
    chk("post_rst_cycle2", out_valid, 1'b1);
    chk("post_rst_result", result_out, 8'hFF);
    @(posedge clk);
    #1;
    drain("drain_post_rst");
    repeat (4) @(posedge clk);
    #1;

    // Random in_valid gaps and out_ready over the directed tables
    pb = popped;
    rand_mode = 1'b1;
    repeat (3) begin
      foreach (stream_v[i]) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(stream_v[i]);
      end
      foreach (flag_v[i]) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(flag_v[i]);
      end
    end
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("drain_random");
    chk("random_count", popped - pb, 48);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
